// File: rtl/ahb_fifo_io_pkg.sv
// Shared types and constants for the AES AHB-Lite front end: transfer types,
// response codes, the register map and its decoder.
package ahb_fifo_io_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  localparam logic [31:0] ADDR_STATUS  = 32'h0000_0000;
  localparam logic [31:0] ADDR_ENCRYPT = 32'h0000_0004;
  localparam logic [31:0] ADDR_DECRYPT = 32'h0000_0008;
  localparam logic [31:0] KEY_BASE     = 32'h0000_0010;
  localparam logic [31:0] KEY_LIMIT    = 32'h0000_001F;
  localparam logic [31:0] DATA_BASE    = 32'h0000_0040;
  localparam logic [31:0] DATA_LIMIT   = 32'h0000_007F;
  localparam logic [31:0] TX_BASE      = 32'h0000_0080;
  localparam logic [31:0] TX_LIMIT     = 32'h0000_00BF;

  typedef enum logic [2:0] {
    REGION_STATUS,
    REGION_ENCRYPT,
    REGION_DECRYPT,
    REGION_KEY,
    REGION_DATA,
    REGION_TX,
    REGION_ERROR
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } dphase_t;

  // A matching address with the wrong direction falls through to REGION_ERROR.
  function automatic region_t decode_region(input logic [31:0] addr, input logic write);
    logic [31:0] a;
    region_t     r;
    a = {addr[31:2], 2'b00};
    r = REGION_ERROR;
    if (a == ADDR_STATUS && !write) r = REGION_STATUS;
    else if (a == ADDR_ENCRYPT && write) r = REGION_ENCRYPT;
    else if (a == ADDR_DECRYPT && write) r = REGION_DECRYPT;
    else if (a >= KEY_BASE && a <= KEY_LIMIT && write) r = REGION_KEY;
    else if (a >= DATA_BASE && a <= DATA_LIMIT && write) r = REGION_DATA;
    else if (a >= TX_BASE && a <= TX_LIMIT && !write) r = REGION_TX;
    return r;
  endfunction

endpackage

// File: rtl/ahb_fifo_io_fifo.sv
// Synchronous first-word-fall-through FIFO; the head reads as zero while empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_COUNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (do_push && !do_pop) count_d = count_q + (PTR_W + 1)'(1);
    else if (do_pop && !do_push) count_d = count_q - (PTR_W + 1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_COUNT);
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/ahb_fifo_io.sv
// AHB-Lite slave front end of the AES core: 32-bit bus words <-> 128-bit blocks.
// Define AHB_FIFO_IO_OVF_ERR_EN to enable the sticky framing_error flag.
module ahb_fifo_io
  import ahb_fifo_io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         HSELx,
  input  logic [31:0]  HADDR,
  input  logic [2:0]   HBURST,
  input  logic [3:0]   HPROT,
  input  logic [2:0]   HSIZE,
  input  logic [1:0]   HTRANS,
  input  logic [31:0]  HWDATA,
  input  logic         HWRITE,
  input  logic [7:0]   status,
  input  logic [127:0] data_in,
  input  logic         tx_enq,
  input  logic         rcv_deq,
  input  logic         fix_error,
  output logic [31:0]  HRDATA,
  output logic         HREADY,
  output logic [1:0]   HRESP,
  output logic         is_encrypt_pulse,
  output logic         is_decrypt_pulse,
  output logic         key_in,
  output logic [127:0] rcv_fifo_out,
  output logic         tx_fifo_full,
  output logic         tx_fifo_empty,
  output logic         rcv_fifo_full,
  output logic         rcv_fifo_empty,
  output logic         framing_error
);

  dphase_t      state_q, state_d;
  region_t      region_q, region_d, addr_region;
  htrans_t      htrans;
  logic [1:0]   word_cnt_q, word_cnt_d;
  logic [95:0]  asm_q, asm_d;
  logic         accept;
  logic         rcv_push, tx_pop, tx_rd_empty;
  logic [128:0] rcv_wdata, rcv_head;
  logic [127:0] tx_head;
  logic [31:0]  tx_word;

  assign htrans = htrans_t'(HTRANS);
  assign HREADY = (state_q != ST_ERR1);
  assign HRESP  = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

  always_comb begin
    addr_region = decode_region(HADDR, HWRITE);
    accept      = HSELx && HREADY && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
  end

  always_comb begin
    tx_word = 32'd0;
    case (word_cnt_q)
      2'd0: tx_word = tx_head[127:96];
      2'd1: tx_word = tx_head[95:64];
      2'd2: tx_word = tx_head[63:32];
      2'd3: tx_word = tx_head[31:0];
      default: tx_word = 32'd0;
    endcase
  end

  // Data-phase actions for the registered region, then the address-phase capture.
  always_comb begin
    state_d          = state_q;
    region_d         = region_q;
    word_cnt_d       = word_cnt_q;
    asm_d            = asm_q;
    HRDATA           = 32'd0;
    is_encrypt_pulse = 1'b0;
    is_decrypt_pulse = 1'b0;
    rcv_push         = 1'b0;
    tx_pop           = 1'b0;
    tx_rd_empty      = 1'b0;
    rcv_wdata        = {(region_q == REGION_KEY), asm_q, HWDATA};

    if (state_q == ST_DATA) begin
      case (region_q)
        REGION_STATUS: HRDATA = {20'd0, rcv_fifo_full, rcv_fifo_empty,
                                 tx_fifo_full, tx_fifo_empty, status};
        REGION_ENCRYPT: is_encrypt_pulse = 1'b1;
        REGION_DECRYPT: is_decrypt_pulse = 1'b1;
        REGION_KEY, REGION_DATA: begin
          word_cnt_d = word_cnt_q + 2'd1;
          case (word_cnt_q)
            2'd0: asm_d[95:64] = HWDATA;
            2'd1: asm_d[63:32] = HWDATA;
            2'd2: asm_d[31:0]  = HWDATA;
            default: rcv_push  = 1'b1;
          endcase
        end
        REGION_TX: begin
          HRDATA      = tx_word;
          word_cnt_d  = word_cnt_q + 2'd1;
          tx_pop      = (word_cnt_q == 2'd3);
          tx_rd_empty = tx_fifo_empty;
        end
        default: ;
      endcase
    end

    if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
    end else if (accept) begin
      region_d = addr_region;
      if (addr_region == REGION_ERROR) begin
        state_d = ST_ERR1;
      end else begin
        state_d = ST_DATA;
        if (htrans == HTRANS_NONSEQ) word_cnt_d = 2'd0;
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) begin
      state_q    <= ST_IDLE;
      region_q   <= REGION_STATUS;
      word_cnt_q <= 2'd0;
      asm_q      <= '0;
    end else begin
      state_q    <= state_d;
      region_q   <= region_d;
      word_cnt_q <= word_cnt_d;
      asm_q      <= asm_d;
    end
  end

  sync_fifo #(.WIDTH(129), .DEPTH(FIFO_DEPTH)) u_rcv_fifo (
    .clk   (HCLK),
    .reset (HRESETn),
    .push  (rcv_push),
    .wdata (rcv_wdata),
    .pop   (rcv_deq),
    .rdata (rcv_head),
    .full  (rcv_fifo_full),
    .empty (rcv_fifo_empty)
  );

  sync_fifo #(.WIDTH(128), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (HCLK),
    .reset (HRESETn),
    .push  (tx_enq),
    .wdata (data_in),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_fifo_full),
    .empty (tx_fifo_empty)
  );

  assign key_in       = rcv_head[128];
  assign rcv_fifo_out = rcv_head[127:0];

`ifdef AHB_FIFO_IO_OVF_ERR_EN
  logic framing_error_q, framing_error_d;

  // Setting wins over fix_error so an overflow in the clearing cycle is not lost.
  always_comb begin
    framing_error_d = framing_error_q;
    if (fix_error) framing_error_d = 1'b0;
    if ((rcv_push && rcv_fifo_full) || tx_rd_empty) framing_error_d = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRESETn) framing_error_q <= 1'b0;
    else         framing_error_q <= framing_error_d;
  end

  assign framing_error = framing_error_q;
`else
  logic unused_cfg;
  assign unused_cfg    = fix_error ^ tx_rd_empty;
  assign framing_error = 1'b0;
`endif

  logic unused_bus;
  assign unused_bus = ^{HBURST, HPROT, HSIZE, HADDR[1:0]};

endmodule

// File: tb/tb_ahb_fifo_io.sv
// Directed bench for ahb_fifo_io: a register-map vector table plus hand-written
// burst, FIFO and error-response sequences.
module tb_ahb_fifo_io;

  logic         HCLK = 1'b0;
  logic         HRESETn;
  logic         HSELx;
  logic [31:0]  HADDR;
  logic [2:0]   HBURST;
  logic [3:0]   HPROT;
  logic [2:0]   HSIZE;
  logic [1:0]   HTRANS;
  logic [31:0]  HWDATA;
  logic         HWRITE;
  logic [7:0]   status;
  logic [127:0] data_in;
  logic         tx_enq;
  logic         rcv_deq;
  logic         fix_error;
  logic [31:0]  HRDATA;
  logic         HREADY;
  logic [1:0]   HRESP;
  logic         is_encrypt_pulse;
  logic         is_decrypt_pulse;
  logic         key_in;
  logic [127:0] rcv_fifo_out;
  logic         tx_fifo_full;
  logic         tx_fifo_empty;
  logic         rcv_fifo_full;
  logic         rcv_fifo_empty;
  logic         framing_error;

  int checks = 0;
  int errors = 0;

  logic [31:0]  wr_words [32];
  logic [31:0]  rd_exp   [32];
  logic [127:0] blk_exp  [4];

  typedef struct {
    string       name;
    logic [31:0] haddr;
    logic        hwrite;
    logic        exp_err;
    logic        exp_enc;
    logic        exp_dec;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  ahb_fifo_io #(.FIFO_DEPTH(4)) dut (
    .HCLK             (HCLK),
    .HRESETn          (HRESETn),
    .HSELx            (HSELx),
    .HADDR            (HADDR),
    .HBURST           (HBURST),
    .HPROT            (HPROT),
    .HSIZE            (HSIZE),
    .HTRANS           (HTRANS),
    .HWDATA           (HWDATA),
    .HWRITE           (HWRITE),
    .status           (status),
    .data_in          (data_in),
    .tx_enq           (tx_enq),
    .rcv_deq          (rcv_deq),
    .fix_error        (fix_error),
    .HRDATA           (HRDATA),
    .HREADY           (HREADY),
    .HRESP            (HRESP),
    .is_encrypt_pulse (is_encrypt_pulse),
    .is_decrypt_pulse (is_decrypt_pulse),
    .key_in           (key_in),
    .rcv_fifo_out     (rcv_fifo_out),
    .tx_fifo_full     (tx_fifo_full),
    .tx_fifo_empty    (tx_fifo_empty),
    .rcv_fifo_full    (rcv_fifo_full),
    .rcv_fifo_empty   (rcv_fifo_empty),
    .framing_error    (framing_error)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  task automatic check_bit(input string name, input logic actual, input logic expected);
    checkOutput(name, {127'd0, actual}, {127'd0, expected});
  endtask

  task automatic check_word(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    checkOutput(name, {96'd0, actual}, {96'd0, expected});
  endtask

  task automatic add_vec(input string name, input logic [31:0] haddr, input logic hwrite,
                         input logic err, input logic enc, input logic dec,
                         input logic chk_rd, input logic [31:0] exp_rd);
    vec_t v;
    v.name = name;  v.haddr = haddr;  v.hwrite = hwrite;
    v.exp_err = err;  v.exp_enc = enc;  v.exp_dec = dec;
    v.chk_rd = chk_rd;  v.exp_rd = exp_rd;
    vecs.push_back(v);
  endtask

  // One single NONSEQ transfer followed by its data phase (two cycles when an error).
  task automatic applyStimulus(input vec_t v);
    HTRANS = 2'd2;
    HADDR  = v.haddr;
    HWRITE = v.hwrite;
    next_cycle();
    HTRANS = 2'd0;
    HADDR  = 32'd0;
    HWRITE = 1'b0;
    HWDATA = 32'hDEAD_BEEF;
    #2;
    check_bit({v.name, "_hready"}, HREADY, !v.exp_err);
    check_word({v.name, "_hresp"}, {30'd0, HRESP}, v.exp_err ? 32'd1 : 32'd0);
    check_bit({v.name, "_enc"}, is_encrypt_pulse, v.exp_enc);
    check_bit({v.name, "_dec"}, is_decrypt_pulse, v.exp_dec);
    if (v.chk_rd) check_word({v.name, "_hrdata"}, HRDATA, v.exp_rd);
    next_cycle();
    if (v.exp_err) begin
      #2;
      check_bit({v.name, "_err2_hready"}, HREADY, 1'b1);
      check_word({v.name, "_err2_hresp"}, {30'd0, HRESP}, 32'd1);
      next_cycle();
    end
  endtask

  // Pipelined burst; a second NONSEQ starts at beat 'split' from base2.
  task automatic ahb_burst(input logic [31:0] base, input logic [31:0] base2, input int split,
                           input int n, input logic write, input int deq_at);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HTRANS = (i == 0 || i == split) ? 2'd2 : 2'd3;
        HADDR  = (i < split) ? base + 32'(4 * i) : base2 + 32'(4 * (i - split));
        HWRITE = write;
      end else begin
        HTRANS = 2'd0;
        HADDR  = 32'd0;
        HWRITE = 1'b0;
      end
      HWDATA  = (i > 0 && write) ? wr_words[i-1] : 32'd0;
      rcv_deq = (i == deq_at);
      #2;
      if (i > 0) begin
        check_bit($sformatf("burst_hready_%0d", i), HREADY, 1'b1);
        if (!write) check_word($sformatf("burst_hrdata_%0d", i - 1), HRDATA, rd_exp[i-1]);
      end
      next_cycle();
    end
    rcv_deq = 1'b0;
  endtask

  task automatic deq_one();
    rcv_deq = 1'b1;
    next_cycle();
    rcv_deq = 1'b0;
    #2;
  endtask

  task automatic load_block(input int slot, input logic [127:0] blk);
    for (int k = 0; k < 4; k++) wr_words[slot*4 + k] = blk[127 - 32*k -: 32];
  endtask

  logic [127:0] blk_a, blk_b;

  initial begin
    HRESETn = 1'b1;  HSELx = 1'b1;  HADDR = 32'd0;  HBURST = 3'd0;  HPROT = 4'd0;
    HSIZE = 3'd2;  HTRANS = 2'd0;  HWDATA = 32'd0;  HWRITE = 1'b0;  status = 8'hA5;
    data_in = '0;  tx_enq = 1'b0;  rcv_deq = 1'b0;  fix_error = 1'b0;
    repeat (3) next_cycle();
    HRESETn = 1'b0;
    #2;
    check_bit("rst_rcv_empty", rcv_fifo_empty, 1'b1);
    check_bit("rst_rcv_full", rcv_fifo_full, 1'b0);
    check_bit("rst_tx_empty", tx_fifo_empty, 1'b1);
    check_bit("rst_tx_full", tx_fifo_full, 1'b0);
    check_bit("rst_hready", HREADY, 1'b1);
    check_word("rst_hresp", {30'd0, HRESP}, 32'd0);
    check_word("rst_hrdata", HRDATA, 32'd0);
    check_bit("rst_key_in", key_in, 1'b0);
    checkOutput("rst_rcv_out", rcv_fifo_out, 128'd0);
    check_bit("rst_framing", framing_error, 1'b0);
    next_cycle();

    add_vec("rd_status",   32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_05A5);
    add_vec("rd_status_lo",32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_05A5);
    add_vec("wr_status",   32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec("wr_encrypt",  32'h0000_0004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec("wr_enc_lo",   32'h0000_0006, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    add_vec("rd_encrypt",  32'h0000_0004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec("wr_decrypt",  32'h0000_0008, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    add_vec("wr_hole_0c",  32'h0000_000C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec("rd_key",      32'h0000_0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec("wr_hole_20",  32'h0000_0020, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec("rd_data",     32'h0000_0040, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec("wr_tx",       32'h0000_0080, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec("rd_tx_empty", 32'h0000_0080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
    add_vec("wr_hole_c0",  32'h0000_00C0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec("rd_128",      32'h0000_0128, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    add_vec("rd_high",     32'h0001_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Single key block lands at the rcv head tagged as a key.
    blk_a = "ZXCVBNMASDFGHJKL";
    load_block(0, blk_a);
    ahb_burst(32'h10, 32'h0, 99, 4, 1'b1, -1);
    next_cycle();
    #2;
    checkOutput("key_head", rcv_fifo_out, blk_a);
    check_bit("key_tag", key_in, 1'b1);
    check_bit("key_not_empty", rcv_fifo_empty, 1'b0);
    deq_one();
    check_bit("key_deq_empty", rcv_fifo_empty, 1'b1);

    // Key burst immediately followed by a NONSEQ data burst.
    blk_b = "1234567890123456";
    load_block(0, blk_a);
    load_block(1, blk_b);
    ahb_burst(32'h10, 32'h40, 4, 8, 1'b1, -1);
    #2;
    checkOutput("kd_head_key", rcv_fifo_out, blk_a);
    check_bit("kd_tag_key", key_in, 1'b1);
    deq_one();
    checkOutput("kd_head_data", rcv_fifo_out, blk_b);
    check_bit("kd_tag_data", key_in, 1'b0);
    deq_one();
    check_bit("kd_empty", rcv_fifo_empty, 1'b1);

    // 16-word data burst with a dequeue while the burst is still running.
    for (int i = 0; i < 16; i++) wr_words[i] = 32'hC0DE_0000 | 32'(i * 17);
    for (int b = 0; b < 4; b++)
      blk_exp[b] = {wr_words[4*b], wr_words[4*b+1], wr_words[4*b+2], wr_words[4*b+3]};
    ahb_burst(32'h40, 32'h0, 99, 16, 1'b1, 6);
    #2;
    for (int b = 1; b < 4; b++) begin
      checkOutput($sformatf("b16_head_%0d", b), rcv_fifo_out, blk_exp[b]);
      check_bit($sformatf("b16_tag_%0d", b), key_in, 1'b0);
      deq_one();
    end
    check_bit("b16_empty", rcv_fifo_empty, 1'b1);

    // Fill rcv to capacity; a fifth block is dropped.
    for (int i = 0; i < 16; i++) wr_words[i] = 32'h7700_0000 + 32'(i * 3);
    for (int b = 0; b < 4; b++)
      blk_exp[b] = {wr_words[4*b], wr_words[4*b+1], wr_words[4*b+2], wr_words[4*b+3]};
    ahb_burst(32'h40, 32'h0, 99, 16, 1'b1, -1);
    #2;
    check_bit("full_rcv_full", rcv_fifo_full, 1'b1);
    load_block(0, 128'hFFFF_0001_FFFF_0002_FFFF_0003_FFFF_0004);
    next_cycle();
    ahb_burst(32'h40, 32'h0, 99, 4, 1'b1, -1);
    #2;
    check_bit("full_still_full", rcv_fifo_full, 1'b1);
    for (int b = 0; b < 4; b++) begin
      checkOutput($sformatf("full_head_%0d", b), rcv_fifo_out, blk_exp[b]);
      deq_one();
    end
    check_bit("full_drained", rcv_fifo_empty, 1'b1);

    // Single tx block read back as four words.
    next_cycle();
    data_in = "1234567891234567";
    tx_enq  = 1'b1;
    next_cycle();
    tx_enq  = 1'b0;
    #2;
    check_bit("tx_not_empty", tx_fifo_empty, 1'b0);
    rd_exp[0] = 32'h3132_3334;  rd_exp[1] = 32'h3536_3738;
    rd_exp[2] = 32'h3931_3233;  rd_exp[3] = 32'h3435_3637;
    next_cycle();
    ahb_burst(32'h80, 32'h0, 99, 4, 1'b0, -1);
    #2;
    check_bit("tx_empty_after", tx_fifo_empty, 1'b1);

    // Fill tx to capacity; the fifth enqueue is dropped.
    next_cycle();
    for (int b = 0; b < 5; b++) begin
      data_in = {4{32'h1111_0000 + 32'(b)}} ^ {32'h0, 32'h100, 32'h200, 32'h300};
      if (b < 4) blk_exp[b] = data_in;
      tx_enq = 1'b1;
      if (b == 4) begin
        #2;
        check_bit("tx_full", tx_fifo_full, 1'b1);
      end
      next_cycle();
    end
    tx_enq = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++) rd_exp[4*b + k] = blk_exp[b][127 - 32*k -: 32];
    ahb_burst(32'h80, 32'h0, 99, 16, 1'b0, -1);
    #2;
    check_bit("tx_full_drained", tx_fifo_empty, 1'b1);

    // Error response on an unmapped write, with no side effects.
    next_cycle();
    HTRANS = 2'd2;  HADDR = 32'h0000_0128;  HWRITE = 1'b1;
    next_cycle();
    HTRANS = 2'd0;  HADDR = 32'd0;  HWRITE = 1'b0;  HWDATA = 32'h1234_5678;
    #2;
    check_bit("err_c1_hready", HREADY, 1'b0);
    check_word("err_c1_hresp", {30'd0, HRESP}, 32'd1);
    next_cycle();
    #2;
    check_bit("err_c2_hready", HREADY, 1'b1);
    check_word("err_c2_hresp", {30'd0, HRESP}, 32'd1);
    next_cycle();
    #2;
    check_word("err_after_hresp", {30'd0, HRESP}, 32'd0);
    check_bit("err_rcv_empty", rcv_fifo_empty, 1'b1);

    // Back-to-back decrypt then encrypt commands: each pulse lasts one cycle.
    next_cycle();
    HTRANS = 2'd2;  HADDR = 32'h08;  HWRITE = 1'b1;
    next_cycle();
    HADDR = 32'h04;
    #2;
    check_bit("cmd_dec_hi", is_decrypt_pulse, 1'b1);
    check_bit("cmd_enc_lo", is_encrypt_pulse, 1'b0);
    next_cycle();
    HTRANS = 2'd0;  HADDR = 32'd0;  HWRITE = 1'b0;
    #2;
    check_bit("cmd_enc_hi", is_encrypt_pulse, 1'b1);
    check_bit("cmd_dec_lo", is_decrypt_pulse, 1'b0);
    next_cycle();
    #2;
    check_bit("cmd_enc_done", is_encrypt_pulse, 1'b0);
    check_bit("cmd_dec_done", is_decrypt_pulse, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
